dp_ctrl: RTL and testbench

Command sequencer for the 3-bit datapath `DP`: register file, ALU, input mux `s1` and output enable `s2`. It accepts one command per handshake. Optionally it loads `in1`/`in2` into the register file, runs one ALU operation, and writes the result back to a destination register. It then presents that register on `DP.out` and pulses `done`. It sits between the host/test logic and `DP`, and replaces hand-driven control sequences.

---
 rtl/dp_pkg.sv | 33 +++
 rtl/dp_ctrl_if.sv | 24 ++
 rtl/dp.sv | 50 +++++
 rtl/dp_ctrl.sv | 145 ++++++++++++++
 tb/tb_dp_ctrl.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared encodings for the 3-bit datapath DP and its command sequencer dp_ctrl.
package dp_pkg;

    localparam logic [1:0] ALU_ADD = 2'b11;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_AND = 2'b01;
    localparam logic [1:0] ALU_XOR = 2'b00;

    localparam logic [1:0] SEL_IN1 = 2'b11;
    localparam logic [1:0] SEL_IN2 = 2'b10;
    localparam logic [1:0] SEL_ALU = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        LD1,
        LD2,
        EXEC,
        SHOW
    } state_t;

    // 3-bit modulo ALU; carry and borrow fall off the top.
    function automatic logic [2:0] alu_eval(input logic [1:0] op,
                                            input logic [2:0] x,
                                            input logic [2:0] y);
        case (op)
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            default: return x ^ y;
        endcase
    endfunction

endpackage

// File: rtl/dp_ctrl_if.sv
// Command handshake between a host and dp_ctrl: one command per valid/ready transfer.
interface dp_ctrl_if #(
    parameter int ADDR_W = 2
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_ld;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_a;
    logic [ADDR_W-1:0] cmd_b;
    logic [ADDR_W-1:0] cmd_d;

    modport master (
        output cmd_valid, cmd_ld, cmd_op, cmd_a, cmd_b, cmd_d,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_ld, cmd_op, cmd_a, cmd_b, cmd_d,
        output cmd_ready
    );

endinterface

// File: rtl/dp.sv
// 3-bit datapath: register file, ALU, write-data mux (s1) and output enable (s2).
module DP
    import dp_pkg::*;
#(
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic [2:0]        in1,
    input  logic [2:0]        in2,
    input  logic [1:0]        s1,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic              rea,
    input  logic [ADDR_W-1:0] raa,
    input  logic              reb,
    input  logic [ADDR_W-1:0] rab,
    input  logic [1:0]        c,
    input  logic              s2,
    output logic [2:0]        out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [2:0] rf [DEPTH];
    logic [2:0] op_a;
    logic [2:0] op_b;
    logic [2:0] alu;
    logic [2:0] wdata;

    // Disabled read ports feed zero into the ALU.
    always_comb begin
        op_a = rea ? rf[raa] : 3'b000;
        op_b = reb ? rf[rab] : 3'b000;
        alu  = alu_eval(c, op_a, op_b);
        case (s1)
            SEL_IN1: wdata = in1;
            SEL_IN2: wdata = in2;
            default: wdata = alu;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) begin
            rf[wa] <= wdata;
        end
    end

    assign out = s2 ? alu : 3'b000;

endmodule

// File: rtl/dp_ctrl.sv
// Command sequencer for DP: optional operand load, one ALU operation with write-back,
// then the destination register is shown on DP.out for HOLD_CYCLES cycles.
module dp_ctrl
    import dp_pkg::*;
#(
    parameter int ADDR_W      = 2,
    parameter int HOLD_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dp_ctrl_if.slave          cmd,
    output logic [1:0]        s1,
    output logic              we,
    output logic [ADDR_W-1:0] wa,
    output logic              rea,
    output logic [ADDR_W-1:0] raa,
    output logic              reb,
    output logic [ADDR_W-1:0] rab,
    output logic [1:0]        c,
    output logic              s2,
    output logic              busy,
    output logic              done
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYCLES);

    state_t            state;
    logic [3:0]        hold_cnt;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] a_q;
    logic [ADDR_W-1:0] b_q;
    logic [ADDR_W-1:0] d_q;

    // Outputs are registered: each branch writes the control word of the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_cnt      <= 4'd0;
            op_q          <= ALU_XOR;
            a_q           <= '0;
            b_q           <= '0;
            d_q           <= '0;
            cmd.cmd_ready <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            s1            <= SEL_ALU;
            we            <= 1'b0;
            wa            <= '0;
            rea           <= 1'b0;
            raa           <= '0;
            reb           <= 1'b0;
            rab           <= '0;
            c             <= ALU_XOR;
            s2            <= 1'b0;
        end else begin
            s1   <= SEL_ALU;
            we   <= 1'b0;
            wa   <= '0;
            rea  <= 1'b0;
            raa  <= '0;
            reb  <= 1'b0;
            rab  <= '0;
            c    <= ALU_XOR;
            s2   <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd.cmd_valid && cmd.cmd_ready) begin
                        op_q          <= cmd.cmd_op;
                        a_q           <= cmd.cmd_a;
                        b_q           <= cmd.cmd_b;
                        d_q           <= cmd.cmd_d;
                        busy          <= 1'b1;
                        cmd.cmd_ready <= 1'b0;
                        if (cmd.cmd_ld) begin
                            state <= LD1;
                            s1    <= SEL_IN1;
                            we    <= 1'b1;
                            wa    <= cmd.cmd_a;
                        end else begin
                            state <= EXEC;
                            rea   <= 1'b1;
                            raa   <= cmd.cmd_a;
                            reb   <= 1'b1;
                            rab   <= cmd.cmd_b;
                            c     <= cmd.cmd_op;
                            we    <= 1'b1;
                            wa    <= cmd.cmd_d;
                        end
                    end
                end
                LD1: begin
                    state <= LD2;
                    s1    <= SEL_IN2;
                    we    <= 1'b1;
                    wa    <= b_q;
                end
                LD2: begin
                    state <= EXEC;
                    rea   <= 1'b1;
                    raa   <= a_q;
                    reb   <= 1'b1;
                    rab   <= b_q;
                    c     <= op_q;
                    we    <= 1'b1;
                    wa    <= d_q;
                end
                EXEC: begin
                    // Showing R[d] reuses the ALU as R[d] & R[d].
                    state    <= SHOW;
                    hold_cnt <= HOLD_INIT;
                    rea      <= 1'b1;
                    raa      <= d_q;
                    reb      <= 1'b1;
                    rab      <= d_q;
                    c        <= ALU_AND;
                    s2       <= 1'b1;
                    done     <= (HOLD_INIT == 4'd1);
                end
                SHOW: begin
                    if (hold_cnt == 4'd1) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        cmd.cmd_ready <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt - 4'd1;
                        rea      <= 1'b1;
                        raa      <= d_q;
                        reb      <= 1'b1;
                        rab      <= d_q;
                        c        <= ALU_AND;
                        s2       <= 1'b1;
                        done     <= (hold_cnt == 4'd2);
                    end
                end
                default: begin
                    state         <= IDLE;
                    busy          <= 1'b0;
                    cmd.cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dp_ctrl.sv
// Bench for dp_ctrl driving DP: one HOLD_CYCLES=1 instance for the main sequence,
// one HOLD_CYCLES=3 instance for the extended display window.
module tb_dp_ctrl;
    import dp_pkg::*;

    localparam int         ADDR_W = 2;
    localparam logic [2:0] IN1    = 3'b110;
    localparam logic [2:0] IN2    = 3'b010;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    dp_ctrl_if #(.ADDR_W(ADDR_W)) bus0 ();
    dp_ctrl_if #(.ADDR_W(ADDR_W)) bus1 ();

    logic [1:0]        s1_0, c_0, s1_1, c_1;
    logic              we_0, rea_0, reb_0, s2_0, busy_0, done_0;
    logic              we_1, rea_1, reb_1, s2_1, busy_1, done_1;
    logic [ADDR_W-1:0] wa_0, raa_0, rab_0, wa_1, raa_1, rab_1;
    logic [2:0]        out_0, out_1;

    dp_ctrl #(.ADDR_W(ADDR_W), .HOLD_CYCLES(1)) u_ctrl0 (
        .clk(clk), .rst_n(rst_n), .cmd(bus0),
        .s1(s1_0), .we(we_0), .wa(wa_0), .rea(rea_0), .raa(raa_0), .reb(reb_0), .rab(rab_0),
        .c(c_0), .s2(s2_0), .busy(busy_0), .done(done_0)
    );
    DP #(.ADDR_W(ADDR_W)) u_dp0 (
        .clk(clk), .in1(IN1), .in2(IN2), .s1(s1_0), .we(we_0), .wa(wa_0), .rea(rea_0),
        .raa(raa_0), .reb(reb_0), .rab(rab_0), .c(c_0), .s2(s2_0), .out(out_0)
    );

    dp_ctrl #(.ADDR_W(ADDR_W), .HOLD_CYCLES(3)) u_ctrl1 (
        .clk(clk), .rst_n(rst_n), .cmd(bus1),
        .s1(s1_1), .we(we_1), .wa(wa_1), .rea(rea_1), .raa(raa_1), .reb(reb_1), .rab(rab_1),
        .c(c_1), .s2(s2_1), .busy(busy_1), .done(done_1)
    );
    DP #(.ADDR_W(ADDR_W)) u_dp1 (
        .clk(clk), .in1(IN1), .in2(IN2), .s1(s1_1), .we(we_1), .wa(wa_1), .rea(rea_1),
        .raa(raa_1), .reb(reb_1), .rab(rab_1), .c(c_1), .s2(s2_1), .out(out_1)
    );

    int         n_assert  = 0;
    int         n_fail    = 0;
    int         done_cnt0 = 0;
    int         steps;
    int         cnt_before;
    logic [2:0] mreg [2][4];
    logic [2:0] mreg_save [4];
    logic [2:0] exp_q0 [$];
    logic [2:0] exp_q1 [$];
    logic [1:0] ops [3];

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic logic [2:0] alu_model(input logic [1:0] op, input logic [2:0] x,
                                             input logic [2:0] y);
        logic [3:0] full;
        case (op)
            2'b11:   full = {1'b0, x} + {1'b0, y};
            2'b10:   full = {1'b0, x} - {1'b0, y};
            2'b01:   full = {1'b0, x & y};
            default: full = {1'b0, x ^ y};
        endcase
        return full[2:0];
    endfunction

    // Updates the register-file model, queues the expected result, then holds valid until accepted.
    task automatic applyStimulus(input int sel, input logic ld, input logic [1:0] op,
                                 input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                                 output int n);
        logic [2:0] res;
        logic       ok;
        if (ld) begin
            mreg[sel][a] = IN1;
            mreg[sel][b] = IN2;
        end
        res          = alu_model(op, mreg[sel][a], mreg[sel][b]);
        mreg[sel][d] = res;
        if (sel == 0) begin
            exp_q0.push_back(res);
            bus0.cmd_valid = 1'b1; bus0.cmd_ld = ld; bus0.cmd_op = op;
            bus0.cmd_a = a; bus0.cmd_b = b; bus0.cmd_d = d;
        end else begin
            exp_q1.push_back(res);
            bus1.cmd_valid = 1'b1; bus1.cmd_ld = ld; bus1.cmd_op = op;
            bus1.cmd_a = a; bus1.cmd_b = b; bus1.cmd_d = d;
        end
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 40) begin
            ok = (sel == 0) ? (bus0.cmd_ready === 1'b1) : (bus1.cmd_ready === 1'b1);
            @(negedge clk);
            n++;
        end
        if (sel == 0) bus0.cmd_valid = 1'b0;
        else          bus1.cmd_valid = 1'b0;
        checkOutput($sformatf("accept%0d", sel), 16'(ok), 16'd1);
    endtask

    task automatic waitDone(input int sel, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            seen = (sel == 0) ? (done_0 === 1'b1) : (done_1 === 1'b1);
            if (!seen) @(negedge clk);
        end
        checkOutput({tag, ".done_seen"}, 16'(seen), 16'd1);
    endtask

    // Expected u0 control word per state: 0 IDLE, 1 LD1, 2 LD2, 3 EXEC, 4 SHOW.
    // ctl = {cmd_ready,busy,done,s2,we,rea,reb,s1,c}; adr = {wa,raa,rab}; unlisted fields masked.
    task automatic checkState(input string tag, input int st, input logic [1:0] op,
                              input logic [1:0] a, input logic [1:0] b, input logic [1:0] d,
                              input logic last);
        logic [10:0] e_ctl, m_ctl, o_ctl;
        logic [5:0]  e_adr, m_adr, o_adr;
        m_ctl = 11'h7FF;
        m_adr = 6'h3F;
        case (st)
            0: begin e_ctl = 11'b1_0_0_0_0_0_0_00_00; e_adr = 6'b0; end
            1: begin e_ctl = 11'b0_1_0_0_1_0_0_11_00; e_adr = {a, 4'b0}; m_ctl = 11'h7FC; m_adr = 6'h30; end
            2: begin e_ctl = 11'b0_1_0_0_1_0_0_10_00; e_adr = {b, 4'b0}; m_ctl = 11'h7FC; m_adr = 6'h30; end
            3: begin e_ctl = {9'b0_1_0_0_1_1_1_00, op}; e_adr = {d, a, b}; end
            default: begin
                e_ctl = {2'b01, last, 8'b1_0_1_1_00_01}; e_adr = {2'b00, d, d};
                m_ctl = 11'h7F3; m_adr = 6'h0F;
            end
        endcase
        o_ctl = {bus0.cmd_ready, busy_0, done_0, s2_0, we_0, rea_0, reb_0, s1_0, c_0};
        o_adr = {wa_0, raa_0, rab_0};
        checkOutput({tag, ".ctl"}, 16'(o_ctl & m_ctl), 16'(e_ctl & m_ctl));
        checkOutput({tag, ".adr"}, 16'(o_adr & m_adr), 16'(e_adr & m_adr));
    endtask

    // Scoreboards: each done pulse pops the oldest expected result.
    always @(negedge clk) begin : mon0
        logic [2:0] e;
        if (rst_n && done_0 === 1'b1) begin
            done_cnt0++;
            if (exp_q0.size() == 0) begin
                checkOutput("sb0.spurious_done", 16'(done_0), 16'd0);
            end else begin
                e = exp_q0.pop_front();
                checkOutput("sb0.out", 16'(out_0), 16'(e));
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [2:0] e;
        if (rst_n && done_1 === 1'b1) begin
            if (exp_q1.size() == 0) begin
                checkOutput("sb1.spurious_done", 16'(done_1), 16'd0);
            end else begin
                e = exp_q1.pop_front();
                checkOutput("sb1.out", 16'(out_1), 16'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus0.cmd_valid = 1'b0; bus0.cmd_ld = 1'b0; bus0.cmd_op = 2'b00;
        bus0.cmd_a = 2'b00; bus0.cmd_b = 2'b00; bus0.cmd_d = 2'b00;
        bus1.cmd_valid = 1'b0; bus1.cmd_ld = 1'b0; bus1.cmd_op = 2'b00;
        bus1.cmd_a = 2'b00; bus1.cmd_b = 2'b00; bus1.cmd_d = 2'b00;
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 4; r++) mreg[s][r] = 3'b000;
        ops[0] = ALU_SUB;
        ops[1] = ALU_AND;
        ops[2] = ALU_XOR;

        #2 rst_n = 1'b0;
        repeat (2) step();
        checkState("reset", 0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0);
        checkOutput("reset.u1", 16'({bus1.cmd_ready, busy_1, done_1, s2_1, we_1}), 16'b10000);
        rst_n = 1'b1;
        step();

        $display("[TB] ADD with load, traced cycle by cycle");
        applyStimulus(0, 1'b1, ALU_ADD, 2'd1, 2'd2, 2'd3, steps);
        checkOutput("add.accept_steps", 16'(steps), 16'd1);
        checkState("add.c1", 1, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0); step();
        checkState("add.c2", 2, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0); step();
        checkState("add.c3", 3, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0); step();
        checkState("add.c4", 4, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b1); step();
        checkState("add.c5", 0, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0);

        $display("[TB] SUB / AND / XOR with load");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1'b1, ops[i], 2'd1, 2'd2, 2'd3, steps);
            waitDone(0, $sformatf("op%0d", i));
            checkState($sformatf("op%0d.show", i), 4, ops[i], 2'd1, 2'd2, 2'd3, 1'b1);
            step();
        end

        $display("[TB] XOR without load");
        applyStimulus(0, 1'b0, ALU_XOR, 2'd1, 2'd2, 2'd3, steps);
        checkState("nold.c1", 3, ALU_XOR, 2'd1, 2'd2, 2'd3, 1'b0); step();
        checkState("nold.c2", 4, ALU_XOR, 2'd1, 2'd2, 2'd3, 1'b1); step();
        checkState("nold.c3", 0, ALU_XOR, 2'd1, 2'd2, 2'd3, 1'b0);

        $display("[TB] valid held during busy ADD");
        applyStimulus(0, 1'b1, ALU_ADD, 2'd1, 2'd2, 2'd3, steps);
        applyStimulus(0, 1'b1, ALU_SUB, 2'd1, 2'd2, 2'd3, steps);
        checkOutput("b2b.accept_steps", 16'(steps), 16'd5);
        checkState("b2b.c1", 1, ALU_SUB, 2'd1, 2'd2, 2'd3, 1'b0);
        waitDone(0, "b2b.sub");
        step();

        $display("[TB] reset during LD2");
        for (int r = 0; r < 4; r++) mreg_save[r] = mreg[0][r];
        applyStimulus(0, 1'b1, ALU_ADD, 2'd1, 2'd2, 2'd3, steps);
        step();
        checkState("abort.ld2", 2, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0);
        cnt_before = done_cnt0;
        #1 rst_n = 1'b0;
        #1 checkState("abort.async", 0, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0);
        step();
        rst_n = 1'b1;
        repeat (4) step();
        checkOutput("abort.no_done", 16'(done_cnt0), 16'(cnt_before));
        checkState("abort.idle", 0, ALU_ADD, 2'd1, 2'd2, 2'd3, 1'b0);
        void'(exp_q0.pop_back());
        for (int r = 0; r < 4; r++) mreg[0][r] = mreg_save[r];
        mreg[0][1] = IN1;

        $display("[TB] recovery and operand-aliasing cases");
        applyStimulus(0, 1'b1, ALU_AND, 2'd1, 2'd2, 2'd3, steps);
        waitDone(0, "post_reset"); step();
        applyStimulus(0, 1'b1, ALU_ADD, 2'd1, 2'd1, 2'd0, steps);
        waitDone(0, "a_eq_b"); step();
        applyStimulus(0, 1'b0, ALU_XOR, 2'd0, 2'd1, 2'd0, steps);
        waitDone(0, "d_eq_a"); step();

        $display("[TB] HOLD_CYCLES=3 instance");
        applyStimulus(1, 1'b1, ALU_ADD, 2'd1, 2'd2, 2'd3, steps);
        for (int cyc = 1; cyc <= 7; cyc++) begin
            checkOutput($sformatf("hold3.c%0d", cyc), 16'({s2_1, done_1}),
                        16'({(cyc >= 4 && cyc <= 6), (cyc == 6)}));
            step();
        end

        checkOutput("sb0.drained", 16'(exp_q0.size()), 16'd0);
        checkOutput("sb1.drained", 16'(exp_q1.size()), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
